// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared state, opcode and ALU encodings plus the control-output
//               bundle for the multi-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam int unsigned OP_LOAD  = 0;
    localparam int unsigned OP_STORE = 1;
    localparam int unsigned OP_ADD   = 2;
    localparam int unsigned OP_LDI   = 3;
    localparam int unsigned OP_SUB   = 4;
    localparam int unsigned OP_JMPZ  = 5;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_CMP  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_data_sel;
        logic       mem_read;
        logic       mem_write;
        logic       mem_data_sel;
        logic [1:0] alu_op;
        logic       alu_sel;
        logic       reg_write;
        logic       illegal_op;
        logic       retire;
    } ctrl_out_t;

    // Bundle value presented while reset is held
    localparam ctrl_out_t CTRL_RESET_OUT = '{
        alu_op  : ALU_PASS,
        default : 1'b0
    };

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational map from (state, latched opcode, handshakes,
//               zero flag) to the datapath control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  state_t           state_i,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             run_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             zero_flag_i,
    output ctrl_out_t        ctrl_o
);

    localparam logic [OPC_W-1:0] C_OP_LOAD  = OPC_W'(OP_LOAD);
    localparam logic [OPC_W-1:0] C_OP_STORE = OPC_W'(OP_STORE);
    localparam logic [OPC_W-1:0] C_OP_ADD   = OPC_W'(OP_ADD);
    localparam logic [OPC_W-1:0] C_OP_LDI   = OPC_W'(OP_LDI);
    localparam logic [OPC_W-1:0] C_OP_SUB   = OPC_W'(OP_SUB);
    localparam logic [OPC_W-1:0] C_OP_JMPZ  = OPC_W'(OP_JMPZ);

    logic [1:0] w_alu;
    logic       w_rds;
    logic       w_mds;
    logic       w_is_mem;

    // Per-opcode datapath selects, held unchanged from EXEC through WB
    always_comb begin
        w_alu = ALU_PASS;
        w_rds = 1'b0;
        w_mds = 1'b0;
        case (opcode_i)
            C_OP_ADD:   begin w_alu = ALU_ADD; w_rds = 1'b1; end
            C_OP_SUB:   begin w_alu = ALU_SUB; w_rds = 1'b1; end
            C_OP_LDI:   w_alu = ALU_PASS;
            C_OP_LOAD:  begin w_alu = ALU_ADD; w_rds = 1'b1; w_mds = 1'b1; end
            C_OP_STORE: w_alu = ALU_ADD;
            default:    w_alu = ALU_PASS;
        endcase
    end

    assign w_is_mem = (opcode_i == C_OP_LOAD) || (opcode_i == C_OP_STORE);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_PASS;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.imem_req = run_i;
                if (run_i && imem_ready_i) begin
                    ctrl_o.ir_write = 1'b1;
                    ctrl_o.pc_write = 1'b1;
                end
            end
            ST_DECODE: begin
                ctrl_o.illegal_op = (opcode_i > C_OP_JMPZ);
            end
            ST_EXEC: begin
                if (opcode_i == C_OP_JMPZ) begin
                    ctrl_o.alu_op   = ALU_CMP;
                    ctrl_o.alu_sel  = 1'b1;
                    ctrl_o.pc_write = zero_flag_i;
                    ctrl_o.pc_src   = zero_flag_i;
                    ctrl_o.retire   = 1'b1;
                end else if (w_is_mem) begin
                    // memory ops only form the address here
                    ctrl_o.alu_op = w_alu;
                end else begin
                    ctrl_o.alu_op       = w_alu;
                    ctrl_o.reg_data_sel = w_rds;
                end
            end
            ST_MEM: begin
                ctrl_o.alu_op = w_alu;
                if (opcode_i == C_OP_LOAD) begin
                    ctrl_o.mem_read     = 1'b1;
                    ctrl_o.mem_data_sel = 1'b1;
                    ctrl_o.reg_data_sel = 1'b1;
                end else begin
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.retire    = dmem_ready_i;
                end
            end
            ST_WB: begin
                ctrl_o.alu_op       = w_alu;
                ctrl_o.reg_data_sel = w_rds;
                ctrl_o.mem_data_sel = w_mds;
                ctrl_o.reg_write    = 1'b1;
                ctrl_o.retire       = 1'b1;
            end
            default: ctrl_o.alu_op = ALU_PASS;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory
//               ready-handshakes, illegal-opcode trap and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               zero_flag,
    output logic               imem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               RegDataSel,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemDataSel,
    output logic [1:0]         ALUOp,
    output logic               AluSel,
    output logic               RegWrite,
    output logic               illegal_op,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_count,
    output logic [2:0]         state_o
);

    localparam logic [OPC_W-1:0] C_OP_LOAD  = OPC_W'(OP_LOAD);
    localparam logic [OPC_W-1:0] C_OP_STORE = OPC_W'(OP_STORE);
    localparam logic [OPC_W-1:0] C_OP_JMPZ  = OPC_W'(OP_JMPZ);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_out_t        w_ctrl;
    ctrl_out_t        w_out;
    logic             w_unused_instr;

    assign w_unused_instr = ^instruction[INSTR_W-OPC_W-1:0];

    ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .state_i      (state_q),
        .opcode_i     (opcode_q),
        .run_i        (run),
        .imem_ready_i (imem_ready),
        .dmem_ready_i (dmem_ready),
        .zero_flag_i  (zero_flag),
        .ctrl_o       (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        count_d  = count_q;
        if (w_ctrl.retire) begin
            count_d = count_q + CNT_W'(1);
        end
        case (state_q)
            ST_FETCH: begin
                if (run && imem_ready) begin
                    opcode_d = instruction[INSTR_W-1 -: OPC_W];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: state_d = w_ctrl.illegal_op ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                if ((opcode_q == C_OP_LOAD) || (opcode_q == C_OP_STORE)) begin
                    state_d = ST_MEM;
                end else if (opcode_q == C_OP_JMPZ) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = (opcode_q == C_OP_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset masks the bundle immediately so an aborted access drops its strobes
    assign w_out         = rst ? CTRL_RESET_OUT : w_ctrl;
    assign retired_count = rst ? '0 : count_q;
    assign state_o       = rst ? 3'd0 : state_q;

    assign imem_req   = w_out.imem_req;
    assign IRWrite    = w_out.ir_write;
    assign PCWrite    = w_out.pc_write;
    assign PCSrc      = w_out.pc_src;
    assign RegDataSel = w_out.reg_data_sel;
    assign MemRead    = w_out.mem_read;
    assign MemWrite   = w_out.mem_write;
    assign MemDataSel = w_out.mem_data_sel;
    assign ALUOp      = w_out.alu_op;
    assign AluSel     = w_out.alu_sel;
    assign RegWrite   = w_out.reg_write;
    assign illegal_op = w_out.illegal_op;
    assign retire     = w_out.retire;

endmodule : multicycle_ctrl
`default_nettype wire
